// File: rtl/synth_pkg.sv
// Shared types and constants for the note oscillator voice.
// This file also holds the constant function that builds the sine table.
package synth_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned PHASE_W  = 32;
  localparam int unsigned ENV_W    = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ATTACK  = 2'b01,
    SUSTAIN = 2'b10,
    RELEASE = 2'b11
  } env_state_t;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'b00,
    WAVE_SAW    = 2'b01,
    WAVE_TRI    = 2'b10,
    WAVE_SINE   = 2'b11
  } wave_t;

  // pi in Q30 fixed point
  localparam longint PI_Q30 = 64'sd3373259426;

  // Returns round(32767*sin(2*pi*idx/256)). The value is built from a
  // quarter-wave Taylor series in Q30, so it is evaluated only at elaboration.
  function automatic logic signed [SAMPLE_W-1:0] sine_entry(input int unsigned idx);
    longint      x;
    longint      term;
    longint      acc;
    longint      q;
    int unsigned qi;
    qi = idx % 128;
    if (qi > 64) qi = 128 - qi;
    x    = (longint'(qi) * PI_Q30) / 128;
    term = x;
    acc  = x;
    for (int unsigned k = 1; k <= 6; k++) begin
      term = (term * x) >>> 30;
      term = (term * x) >>> 30;
      term = -term / longint'(4 * k * k + 2 * k);
      acc  = acc + term;
    end
    q = (acc * 32767 + (64'sd1 <<< 29)) >>> 30;
    if (idx >= 128) q = -q;
    return SAMPLE_W'(q);
  endfunction

endpackage

// File: rtl/note_osc_sine_rom.sv
// 256 x 16 signed sine table with a one-cycle registered read.
module sine_rom
  import synth_pkg::*;
(
  input  logic                       clk,
  input  logic [7:0]                 addr,
  output logic signed [SAMPLE_W-1:0] data
);

  logic signed [SAMPLE_W-1:0] table_q [256];

  for (genvar g = 0; g < 256; g++) begin : g_table
    assign table_q[g] = sine_entry(g);
  end

  always_ff @(posedge clk) begin
    data <= table_q[addr];
  end

endmodule

// File: rtl/note_osc.sv
// Per-voice oscillator: phase accumulator, linear attack/release envelope,
// four-waveform shaper and envelope multiply in a 3-stage sample pipeline.
module note_osc
  import synth_pkg::*;
#(
  parameter int unsigned ATTACK_STEP  = 4,
  parameter int unsigned RELEASE_STEP = 1
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [PHASE_W-1:0]         idxjmp,
  input  logic                       sample_tick,
  input  logic [1:0]                 wave_sel,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       sample_valid,
  output logic                       active
);

  localparam logic [ENV_W:0]   A_STEP = (ENV_W + 1)'(ATTACK_STEP);
  localparam logic [ENV_W-1:0] R_STEP = ENV_W'(RELEASE_STEP);

  env_state_t          state, state_next;
  logic [ENV_W-1:0]    env, env_next;
  logic [ENV_W:0]      env_sum;
  logic [ENV_W-1:0]    env_up, env_dn;
  logic [PHASE_W-1:0]  phase, phase_next;
  logic [PHASE_W-1:0]  inc, inc_next;
  logic                key;
  logic                v0;

  assign key = (idxjmp != '0);

  // Stage 0: state register, updated together with phase and env
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
      env   <= '0;
      phase <= '0;
      inc   <= '0;
      v0    <= 1'b0;
    end else begin
      v0 <= sample_tick;
      if (sample_tick) begin
        state <= state_next;
        env   <= env_next;
        phase <= phase_next;
        inc   <= inc_next;
      end
    end
  end

  // Next-state and envelope: any key press outside SUSTAIN steps the envelope up
  always_comb begin
    env_sum    = {1'b0, env} + A_STEP;
    env_up     = env_sum[ENV_W] ? '1 : env_sum[ENV_W-1:0];
    env_dn     = (env > R_STEP) ? env - R_STEP : '0;
    state_next = state;
    env_next   = env;
    if (key) begin
      if (state == SUSTAIN) begin
        env_next = '1;
      end else begin
        env_next   = env_up;
        state_next = (env_up == '1) ? SUSTAIN : ATTACK;
      end
    end else if (state != IDLE) begin
      env_next   = env_dn;
      state_next = (env_dn == '0) ? IDLE : RELEASE;
    end
  end

  // Phase and increment; entering IDLE clears both so the next note starts at 0
  always_comb begin
    inc_next   = key ? idxjmp : inc;
    phase_next = phase + inc_next;
    if (state_next == IDLE) begin
      inc_next   = '0;
      phase_next = '0;
    end
  end

  always_comb begin
    active = (state != IDLE);
  end

  // Stage 1: waveform shaping and ROM read
  logic [7:0]                 p;
  logic [6:0]                 tri_m;
  logic [SAMPLE_W-1:0]        tri_lvl;
  logic signed [SAMPLE_W-1:0] wave_d;
  logic signed [SAMPLE_W-1:0] wave1;
  logic signed [SAMPLE_W-1:0] rom_q;
  wave_t                      sel1;
  logic [ENV_W-1:0]           env1;
  logic                       v1;

  // Triangle: m*516 - 32767 spans -32767..32765, so the apex is pinned to +32767
  always_comb begin
    p       = phase[PHASE_W-1 -: 8];
    tri_m   = p[7] ? ~p[6:0] : p[6:0];
    tri_lvl = {tri_m, 9'b0} + {7'b0, tri_m, 2'b0};
    case (wave_t'(wave_sel))
      WAVE_SQUARE: wave_d = p[7] ? -16'sd32767 : 16'sd32767;
      WAVE_SAW:    wave_d = {p, 8'h00} ^ 16'h8000;
      WAVE_TRI:    wave_d = (tri_m == '1) ? 16'sd32767 : tri_lvl - 16'h7FFF;
      default:     wave_d = '0;
    endcase
  end

  sine_rom u_sine_rom (
    .clk  (Clk),
    .addr (p),
    .data (rom_q)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      v1    <= 1'b0;
      wave1 <= '0;
      sel1  <= WAVE_SQUARE;
      env1  <= '0;
    end else begin
      v1    <= v0;
      wave1 <= wave_d;
      sel1  <= wave_t'(wave_sel);
      env1  <= env;
    end
  end

  // Stage 2: envelope multiply; |wave|*255 fits, so the shifted product cannot overflow
  logic signed [SAMPLE_W-1:0] wave_s;
  logic signed [24:0]         product;

  always_comb begin
    wave_s  = (sel1 == WAVE_SINE) ? rom_q : wave1;
    product = 25'(wave_s) * 25'($signed({1'b0, env1}));
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= v1;
      if (v1) sample <= SAMPLE_W'(product >>> 8);
    end
  end

endmodule

// File: tb/tb_note_osc.sv
// Bench for note_osc: tick-level behavioural model with a per-cycle compare,
// plus literal expectations at known ticks.
module tb_note_osc;

  localparam int ATK    = 4;
  localparam int REL    = 1;
  localparam int M_IDLE = 0;
  localparam int M_ATK  = 1;
  localparam int M_SUS  = 2;
  localparam int M_REL  = 3;
  localparam real PI    = 3.14159265358979323846;

  logic               Clk = 1'b0;
  logic               Reset_n;
  logic               sample_tick;
  logic [31:0]        idxjmp;
  logic [1:0]         wave_sel;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               active;

  note_osc #(.ATTACK_STEP(ATK), .RELEASE_STEP(REL)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .idxjmp       (idxjmp),
    .sample_tick  (sample_tick),
    .wave_sel     (wave_sel),
    .sample       (sample),
    .sample_valid (sample_valid),
    .active       (active)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (per tick) ----------------
  typedef struct {
    int unsigned t;
    int          id;
    logic [31:0] ph;
    int          env;
  } pend_t;

  pend_t       pend_q[$];
  int unsigned edge_n   = 0;
  int unsigned rst_edge = 0;
  int          ws_hist [0:65535];
  int          dut_by_tick [0:4095];
  logic [31:0] m_phase = '0;
  logic [31:0] m_inc   = '0;
  int          m_env   = 0;
  int          m_mode  = M_IDLE;
  int          m_ticks = 0;

  function automatic int wave_of(input int p, input int sel);
    int  m;
    real r;
    case (sel)
      0: return (p < 128) ? 32767 : -32767;
      1: return p * 256 - 32768;
      2: begin
        m = (p < 128) ? p : 255 - p;
        return (m == 127) ? 32767 : m * 516 - 32767;
      end
      default: begin
        r = 32767.0 * $sin(2.0 * PI * real'(p) / 256.0);
        return $rtoi(r >= 0.0 ? r + 0.5 : r - 0.5);
      end
    endcase
  endfunction

  always @(posedge Clk) begin
    edge_n++;
    ws_hist[edge_n % 65536] = int'(wave_sel);
    if (!Reset_n) begin
      m_phase  = '0;
      m_inc    = '0;
      m_env    = 0;
      m_mode   = M_IDLE;
      pend_q.delete();
      rst_edge = edge_n;
    end else if (sample_tick) begin
      m_ticks++;
      if (idxjmp != 0) begin
        m_inc   = idxjmp;
        m_phase = m_phase + idxjmp;
        if (m_mode != M_SUS) begin
          m_env  = (m_env + ATK > 255) ? 255 : m_env + ATK;
          m_mode = (m_env == 255) ? M_SUS : M_ATK;
        end
      end else if (m_mode != M_IDLE) begin
        m_phase = m_phase + m_inc;
        m_env   = (m_env - REL < 0) ? 0 : m_env - REL;
        if (m_env == 0) begin
          m_mode  = M_IDLE;
          m_phase = '0;
          m_inc   = '0;
        end else begin
          m_mode = M_REL;
        end
      end
      pend_q.push_back('{edge_n, m_ticks, m_phase, m_env});
    end
  end

  // ---------------- per-cycle compare ----------------
  int    hold_val = 0;
  int    hold_tol = 0;
  bit    exp_v;
  pend_t e;
  int    sel_e;
  int    diff;

  always @(negedge Clk) begin
    if (rst_edge != 0) begin
      if (rst_edge == edge_n) begin
        hold_val = 0;
        hold_tol = 0;
      end
      exp_v = (pend_q.size() > 0) && (pend_q[0].t + 2 == edge_n);
      checks++;
      if (sample_valid !== exp_v) begin
        failures++;
        $display("FAIL sample_valid @edge %0d: got %0b expected %0b", edge_n, sample_valid, exp_v);
      end
      if (exp_v) begin
        e        = pend_q.pop_front();
        sel_e    = ws_hist[(e.t + 1) % 65536];
        hold_val = (wave_of(int'(e.ph[31:24]), sel_e) * e.env) >>> 8;
        hold_tol = (sel_e == 3) ? 1 : 0;
        if (e.id < 4096) dut_by_tick[e.id] = int'(sample);
      end
      diff = int'(sample) - hold_val;
      checks++;
      if (diff > hold_tol || diff < -hold_tol) begin
        failures++;
        $display("FAIL sample @edge %0d: got %0d expected %0d", edge_n, sample, hold_val);
      end
      checks++;
      if (active !== (m_mode != M_IDLE)) begin
        failures++;
        $display("FAIL active @edge %0d: got %0b expected %0b", edge_n, active, m_mode != M_IDLE);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic [31:0] inc);
    idxjmp      = inc;
    sample_tick = 1'b1;
    @(posedge Clk); #1;
    sample_tick = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clk); #1;
    end
  endtask

  int base;
  int lat;
  int n;
  int run;
  int best;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) dut_by_tick[i] = 999999;
    Reset_n     = 1'b0;
    sample_tick = 1'b0;
    idxjmp      = '0;
    wave_sel    = 2'b01;

    // reset held while ticking a note
    @(posedge Clk); #1;
    idxjmp      = 32'd5000;
    sample_tick = 1'b1;
    idle(2);
    chk("reset_sample", sample, 0);
    chk("reset_valid", sample_valid, 0);
    chk("reset_active", active, 0);

    // first post-reset tick (silent): valid arrives in cycle n+3
    Reset_n = 1'b1;
    idxjmp  = '0;
    @(posedge Clk); #1;
    sample_tick = 1'b0;
    lat = 1;
    while (!sample_valid && lat < 12) begin
      @(posedge Clk); #1;
      lat++;
    end
    chk("first_valid_latency", lat, 3);
    chk("idle_sample_zero", sample, 0);
    idle(3);

    // pitch and attack on saw
    base = m_ticks;
    for (int k = 1; k <= 1000; k++) begin
      tick(32'd19685267);
      if (k == 1)  chk("model_env_tick1", m_env, 4);
      if (k == 63) chk("model_attack_tick63", m_mode, M_ATK);
      if (k == 64) chk("model_sustain_tick64", m_mode, M_SUS);
      if (k == 64) chk("active_tick64", active, 1);
    end
    idle(4);
    chk("model_phase_1000", m_phase, 64'd2505397816);
    chk("saw_tick1", dut_by_tick[base + 1], -508);
    chk("saw_tick64", dut_by_tick[base + 64], -13515);
    chk("saw_tick218", dut_by_tick[base + 218], 32385);
    chk("saw_tick219_wrap", dut_by_tick[base + 219], -32640);

    // release on triangle
    wave_sel = 2'b10;
    n = 0;
    while (active && n < 400) begin
      tick(32'd0);
      n++;
    end
    chk("release_ticks", n, 255);
    for (int k = 0; k < 4; k++) tick(32'd0);
    idle(4);
    chk("idle_after_release_sample", sample, 0);
    chk("idle_after_release_active", active, 0);

    // retrigger from env=100 on sine
    wave_sel = 2'b11;
    for (int k = 0; k < 70; k++) tick(32'd19685267);
    for (int k = 0; k < 155; k++) tick(32'd0);
    chk("model_release_env100", m_env, 100);
    chk("model_release_mode", m_mode, M_REL);
    for (int k = 0; k < 38; k++) tick(32'd23409871);
    chk("model_retrig_env38", m_env, 252);
    chk("model_retrig_mode38", m_mode, M_ATK);
    tick(32'd23409871);
    chk("model_retrig_sustain39", m_mode, M_SUS);
    chk("retrig_active", active, 1);

    // reset mid-note discards in-flight samples
    tick(32'h4000_0000);
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    chk("midnote_reset_active", active, 0);
    idle(4);

    // square at full envelope with back-to-back ticks
    wave_sel = 2'b00;
    base = m_ticks;
    for (int k = 0; k < 64; k++) tick(32'h4000_0000);
    idle(4);
    sample_tick = 1'b1;
    idxjmp      = 32'h4000_0000;
    run  = 0;
    best = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 4) sample_tick = 1'b0;
      @(posedge Clk); #1;
      run  = sample_valid ? run + 1 : 0;
      best = (run > best) ? run : best;
    end
    chk("b2b_valid_run", best, 4);
    chk("square_p64", dut_by_tick[base + 65], 32639);
    chk("square_p128", dut_by_tick[base + 66], -32640);
    chk("square_p192", dut_by_tick[base + 67], -32640);
    chk("square_p0", dut_by_tick[base + 68], 32639);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
